// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: exception codes,
// CP0 register addresses, exception flag bit positions and FSM state encoding.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

  localparam int FLAG_SYS  = 0;
  localparam int FLAG_RI   = 1;
  localparam int FLAG_TR   = 2;
  localparam int FLAG_OV   = 3;
  localparam int FLAG_ERET = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/cp0_fwd.sv
// Combinational forwarding of a WB-stage CP0 write onto the Status/Cause/EPC
// values seen by the exception arbiter.
module cp0_fwd
  import exc_ctrl_pkg::*;
(
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  always_comb begin
    status_o = status_i;
    cause_o  = cause_i;
    epc_o    = epc_i;
    if (we_i) begin
      unique case (waddr_i)
        CP0_ADDR_STATUS: status_o = wdata_i;
        // Only the software-writable Cause fields (IP1:0, IV/WP) are replaced.
        CP0_ADDR_CAUSE: begin
          cause_o[9:8]   = wdata_i[9:8];
          cause_o[23:22] = wdata_i[23:22];
        end
        CP0_ADDR_EPC: epc_o = wdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbitration and redirect controller.
// Optional statistics counters are enabled by defining EXC_CTRL_STATS_EN.
//
// state    | meaning
// ST_IDLE  | accepting exceptions from the MEM instruction
// ST_FLUSH | flush_o high, new_pc_o valid (one cycle)
// ST_DRAIN | lockout window, counting down to IDLE
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [4:0]  exc_flags_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] except_type_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
`ifdef EXC_CTRL_STATS_EN
  ,
  output logic [31:0] exc_count_o,
  output logic [31:0] int_count_o
`endif
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  logic [31:0]   fwd_status, fwd_cause, fwd_epc;
  logic          int_pending;
  logic [31:0]   code;
  logic          taken;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;
  logic [31:0]   new_pc_q, new_pc_d;

  cp0_fwd u_cp0_fwd (
    .we_i     (wb_cp0_we_i),
    .waddr_i  (wb_cp0_waddr_i),
    .wdata_i  (wb_cp0_wdata_i),
    .status_i (cp0_status_i),
    .cause_i  (cp0_cause_i),
    .epc_i    (cp0_epc_i),
    .status_o (fwd_status),
    .cause_o  (fwd_cause),
    .epc_o    (fwd_epc)
  );

  logic unused_fwd_bits;
  assign unused_fwd_bits = ^{fwd_cause[31:16], fwd_cause[7:0],
                             fwd_status[31:16], fwd_status[7:2]};

  assign int_pending = ((fwd_cause[15:8] & fwd_status[15:8]) != 8'h00) &&
                       !fwd_status[1] && fwd_status[0];

  always_comb begin
    code = EXC_NONE;
    if (int_pending)                 code = EXC_INT;
    else if (exc_flags_i[FLAG_SYS])  code = EXC_SYS;
    else if (exc_flags_i[FLAG_RI])   code = EXC_RI;
    else if (exc_flags_i[FLAG_TR])   code = EXC_TR;
    else if (exc_flags_i[FLAG_OV])   code = EXC_OV;
    else if (exc_flags_i[FLAG_ERET]) code = EXC_ERET;
  end

  // Nothing is issued during reset, while locked out, or on a bubble.
  assign except_type_o = (!rst && state_q == ST_IDLE && inst_valid_i) ? code : EXC_NONE;
  assign taken         = (except_type_o != EXC_NONE);

  assign current_inst_addr_o = pc_i;
  assign is_in_delayslot_o   = in_delayslot_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (taken) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = (except_type_o == EXC_ERET) ? fwd_epc : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign flush_o  = flush_q;
  assign new_pc_o = new_pc_q;
  assign busy_o   = (state_q != ST_IDLE);

`ifdef EXC_CTRL_STATS_EN
  logic [31:0] exc_cnt_q, exc_cnt_d;
  logic [31:0] int_cnt_q, int_cnt_d;

  always_comb begin
    exc_cnt_d = exc_cnt_q;
    int_cnt_d = int_cnt_q;
    if (taken && exc_cnt_q != 32'hFFFF_FFFF) exc_cnt_d = exc_cnt_q + 32'd1;
    if (taken && except_type_o == EXC_INT && int_cnt_q != 32'hFFFF_FFFF)
      int_cnt_d = int_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_cnt_q <= 32'h0;
      int_cnt_q <= 32'h0;
    end else begin
      exc_cnt_q <= exc_cnt_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  assign exc_count_o = exc_cnt_q;
  assign int_count_o = int_cnt_q;
`endif

endmodule
